spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 217 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave, mode 0..3 chosen by MODO_SPI, one byte in / one byte out per 8 SPI clocks.
// Optional sticky rx_overrun flag (TX load found nothing to send) under `SPI_SLAVE_OVERRUN_EN.
module spi_slave #(
    parameter int unsigned MODO_SPI = 32'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_dado,
    input  logic       tx_valido,
    output logic       tx_pronto,
    output logic [7:0] rx_dado,
    output logic       rx_valido,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso
`ifdef SPI_SLAVE_OVERRUN_EN
   ,output logic       rx_overrun
`endif
);

    localparam logic CPOL = MODO_SPI[1];
    localparam logic CPHA = MODO_SPI[0];

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CARREGA   = 2'd1,
        TRANSFERE = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    logic       sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_d_q, sclk_d_d;
    logic       cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
    logic       mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_cheio_q, hold_cheio_d;
    logic       deve_shift_q, deve_shift_d;
    logic       byte_fim_q, byte_fim_d;
    logic       tx_pronto_q, tx_pronto_d;
    logic [7:0] rx_dado_q, rx_dado_d;
    logic       rx_valido_q, rx_valido_d;
    logic       spi_miso_q, spi_miso_d;
    logic       carga_s, lead_s, trail_s, amostra_s, desloca_s;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       overrun_q, overrun_d;
`endif

    // Edges are judged on the synchronized clock against its one-cycle-delayed copy.
    assign lead_s    = (sclk_s2_q != CPOL) && (sclk_d_q == CPOL);
    assign trail_s   = (sclk_s2_q == CPOL) && (sclk_d_q != CPOL);
    assign amostra_s = CPHA ? trail_s : lead_s;
    assign desloca_s = CPHA ? lead_s  : trail_s;

    // Next-state logic: synchronizers, transfer FSM, shift registers and holding register.
    always_comb begin
        sclk_s1_d    = spi_clk;
        sclk_s2_d    = sclk_s1_q;
        sclk_d_d     = sclk_s2_q;
        cs_s1_d      = spi_cs_n;
        cs_s2_d      = cs_s1_q;
        mosi_s1_d    = spi_mosi;
        mosi_s2_d    = mosi_s1_q;
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        hold_cheio_d = hold_cheio_q;
        deve_shift_d = deve_shift_q;
        byte_fim_d   = byte_fim_q;
        rx_dado_d    = rx_dado_q;
        rx_valido_d  = 1'b0;
        carga_s      = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        overrun_d    = overrun_q;
`endif
        if ((estado_q != OCIOSO) && cs_s2_q) begin
            // Deselect mid-byte: drop partial RX bits and whatever TX byte was loaded.
            estado_d     = OCIOSO;
            cnt_d        = 3'd0;
            rx_shift_d   = 7'd0;
            tx_shift_d   = 8'h00;
            deve_shift_d = 1'b0;
            byte_fim_d   = 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (!cs_s2_q) begin
                        estado_d = CARREGA;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
                CARREGA: begin
                    carga_s  = 1'b1;
                    estado_d = TRANSFERE;
                end
                TRANSFERE: begin
                    // A shift is owed after every sample, so CPHA=1 ignores the very first leading edge.
                    if (amostra_s) begin
                        rx_shift_d   = {rx_shift_q[5:0], mosi_s2_q};
                        cnt_d        = cnt_q + 3'd1;
                        deve_shift_d = 1'b1;
                        if (cnt_q == 3'd7) begin
                            rx_dado_d   = {rx_shift_q, mosi_s2_q};
                            rx_valido_d = 1'b1;
                            byte_fim_d  = 1'b1;
                        end else begin
                            byte_fim_d  = 1'b0;
                        end
                    end else if (desloca_s && deve_shift_q) begin
                        deve_shift_d = 1'b0;
                        if (byte_fim_q) begin
                            carga_s    = 1'b1;
                            byte_fim_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end else begin
                        deve_shift_d = deve_shift_q;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end

        if (carga_s) begin
            if (hold_cheio_q) begin
                tx_shift_d   = hold_q;
                hold_cheio_d = 1'b0;
            end else begin
                tx_shift_d   = 8'h00;
`ifdef SPI_SLAVE_OVERRUN_EN
                overrun_d    = 1'b1;
`endif
            end
        end else begin
            hold_cheio_d = hold_cheio_q;
        end

        // Handshake is evaluated after the load so a coinciding new byte lands behind the old one.
        if (tx_valido && tx_pronto_q) begin
            hold_d       = tx_dado;
            hold_cheio_d = 1'b1;
        end else begin
            hold_d       = hold_q;
        end

        tx_pronto_d = !hold_cheio_d;
        spi_miso_d  = (estado_d == OCIOSO) ? 1'b1 : tx_shift_d[7];
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q    <= CPOL;
            sclk_s2_q    <= CPOL;
            sclk_d_q     <= CPOL;
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            estado_q     <= OCIOSO;
            cnt_q        <= 3'd0;
            rx_shift_q   <= 7'd0;
            tx_shift_q   <= 8'h00;
            hold_q       <= 8'h00;
            hold_cheio_q <= 1'b0;
            deve_shift_q <= 1'b0;
            byte_fim_q   <= 1'b0;
            tx_pronto_q  <= 1'b1;
            rx_dado_q    <= 8'h00;
            rx_valido_q  <= 1'b0;
            spi_miso_q   <= 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_q    <= 1'b0;
`endif
        end else begin
            sclk_s1_q    <= sclk_s1_d;
            sclk_s2_q    <= sclk_s2_d;
            sclk_d_q     <= sclk_d_d;
            cs_s1_q      <= cs_s1_d;
            cs_s2_q      <= cs_s2_d;
            mosi_s1_q    <= mosi_s1_d;
            mosi_s2_q    <= mosi_s2_d;
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_cheio_q <= hold_cheio_d;
            deve_shift_q <= deve_shift_d;
            byte_fim_q   <= byte_fim_d;
            tx_pronto_q  <= tx_pronto_d;
            rx_dado_q    <= rx_dado_d;
            rx_valido_q  <= rx_valido_d;
            spi_miso_q   <= spi_miso_d;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_q    <= overrun_d;
`endif
        end
    end

    assign tx_pronto = tx_pronto_q;
    assign rx_dado   = rx_dado_q;
    assign rx_valido = rx_valido_q;
    assign spi_miso  = spi_miso_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign rx_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode, bench acts as SPI master.
module tb_spi_slave;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sclk, cs_n, mosi, tx_valido, tx_pronto, rx_valido, miso;
    logic [7:0] tx_dado [4];
    logic [7:0] rx_dado [4];
`ifdef SPI_SLAVE_OVERRUN_EN
    logic [3:0] ovr;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    int         pulsos [4] = '{default: 0};
    logic [7:0] hist [4][4];
    logic [7:0] r;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.MODO_SPI(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_dado   (tx_dado[g]),
            .tx_valido (tx_valido[g]),
            .tx_pronto (tx_pronto[g]),
            .rx_dado   (rx_dado[g]),
            .rx_valido (rx_valido[g]),
            .spi_clk   (sclk[g]),
            .spi_cs_n  (cs_n[g]),
            .spi_mosi  (mosi[g]),
            .spi_miso  (miso[g])
`ifdef SPI_SLAVE_OVERRUN_EN
           ,.rx_overrun(ovr[g])
`endif
        );
    end

    // Every high cycle of rx_valido is counted, so a stretched pulse shows up as an extra byte.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valido[i] === 1'b1) begin
                pulsos[i] <= pulsos[i] + 1;
                if (pulsos[i] < 4) hist[i][pulsos[i]] <= rx_dado[i];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input int m, input logic [7:0] d);
        int t = 0;
        while (tx_pronto[m] !== 1'b1 && t < 100) begin
            tick(1);
            t++;
        end
        check_eq("push_tx_pronto", 8'(tx_pronto[m]), 8'h01);
        tx_dado[m]   = d;
        tx_valido[m] = 1'b1;
        tick(1);
        tx_valido[m] = 1'b0;
    endtask

    task automatic cs_baixo(input int m);
        cs_n[m] = 1'b0;
        tick(8);
    endtask

    task automatic cs_alto(input int m);
        tick(H);
        cs_n[m] = 1'b1;
        tick(8);
    endtask

    task automatic byte_xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic cpol, cpha;
        logic [1:0] mm;
        mm   = 2'(m);
        cpol = mm[1];
        cpha = mm[0];
        rx   = 8'h00;
        for (int b = 7; b >= 8 - nbits; b--) begin
            if (!cpha) begin
                mosi[m] = tx[b];
                tick(H);
                rx[b]   = miso[m];
                sclk[m] = ~cpol;
                tick(H);
                sclk[m] = cpol;
            end else begin
                tick(H);
                sclk[m] = ~cpol;
                mosi[m] = tx[b];
                tick(H);
                rx[b]   = miso[m];
                sclk[m] = cpol;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cs_n      = 4'hF;
        sclk      = 4'b1100;
        mosi      = 4'h0;
        tx_valido = 4'h0;
        for (int i = 0; i < 4; i++) tx_dado[i] = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check_eq("rst_tx_pronto", 8'(tx_pronto), 8'h0F);
        check_eq("rst_miso", 8'(miso), 8'h0F);
        check_eq("rst_rx_valido", 8'(rx_valido), 8'h00);
        check_eq("rst_rx_dado", rx_dado[0], 8'h00);

        // Mode 0, preloaded A5, master sends 3C.
        push_tx(0, 8'hA5);
        cs_baixo(0);
        byte_xfer(0, 8'h3C, 8, r);
        cs_alto(0);
        check_eq("m0_miso_byte", r, 8'hA5);
        check_eq("m0_rx_dado", hist[0][0], 8'h3C);
        check_eq("m0_pulses", 8'(pulsos[0]), 8'd1);
        check_eq("m0_miso_idle", 8'(miso[0]), 8'h01);

        // Mode 3, two bytes back to back with cs held low.
        push_tx(3, 8'h81);
        cs_baixo(3);
        push_tx(3, 8'h7E);
        byte_xfer(3, 8'h01, 8, r);
        check_eq("m3_miso_b0", r, 8'h81);
        byte_xfer(3, 8'h02, 8, r);
        check_eq("m3_miso_b1", r, 8'h7E);
        cs_alto(3);
        check_eq("m3_pulses", 8'(pulsos[3]), 8'd2);
        check_eq("m3_rx_b0", hist[3][0], 8'h01);
        check_eq("m3_rx_b1", hist[3][1], 8'h02);
`ifdef SPI_SLAVE_OVERRUN_EN
        check_eq("m3_overrun", 8'(ovr[3]), 8'h00);
`endif

        // Modes 1 and 2 with nothing to send.
        for (int m = 1; m <= 2; m++) begin
            cs_baixo(m);
            byte_xfer(m, 8'hFF, 8, r);
            cs_alto(m);
            check_eq("m12_miso_zero", r, 8'h00);
            check_eq("m12_rx_dado", hist[m][0], 8'hFF);
            check_eq("m12_pulses", 8'(pulsos[m]), 8'd1);
`ifdef SPI_SLAVE_OVERRUN_EN
            check_eq("m12_overrun", 8'(ovr[m]), 8'h01);
`endif
        end

        // Mode 0, partial byte abandoned by cs_n, then a full byte 55.
        cs_baixo(0);
        byte_xfer(0, 8'hAA, 5, r);
        cs_alto(0);
        check_eq("partial_no_pulse", 8'(pulsos[0]), 8'd1);
        cs_baixo(0);
        byte_xfer(0, 8'h55, 8, r);
        cs_alto(0);
        check_eq("full55_pulses", 8'(pulsos[0]), 8'd2);
        check_eq("full55_rx", hist[0][1], 8'h55);
        check_eq("full55_miso", r, 8'h00);

        // Mode 0, reset in the middle of a byte with the holding register full.
        cs_baixo(0);
        push_tx(0, 8'h99);
        check_eq("pre_rst_pronto", 8'(tx_pronto[0]), 8'h00);
        byte_xfer(0, 8'h0F, 3, r);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_pronto", 8'(tx_pronto[0]), 8'h01);
        check_eq("midrst_rx_dado", rx_dado[0], 8'h00);
        check_eq("midrst_rx_valido", 8'(rx_valido[0]), 8'h00);
        check_eq("midrst_miso", 8'(miso[0]), 8'h01);
        cs_n[0] = 1'b1;
        sclk[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check_eq("postrst_no_pulse", 8'(pulsos[0]), 8'd2);
        cs_baixo(0);
        byte_xfer(0, 8'hC3, 8, r);
        cs_alto(0);
        check_eq("postrst_pulses", 8'(pulsos[0]), 8'd3);
        check_eq("postrst_rx", hist[0][2], 8'hC3);
        check_eq("postrst_rx_dado", rx_dado[0], 8'hC3);
        check_eq("postrst_miso", r, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
